wash_cycle_ctrl: RTL
====================

# wash_cycle_ctrl

Parametrised washing-machine cycle controller, the next-generation controller for the appliance FSM family. Sequences FILL → WASH → DRAIN → (RINSE → DRAIN) × N → SPIN → DONE.
- Stage durations and the rinse count are runtime inputs, latched at start.
- Supports pause/resume, door-interlock fault detection and abort.
- Sits between the front-panel decoder and the valve/motor/pump drivers, which decode `stage`.

## Interface
- `CNT_W`, default 8: stage timer width; max stage duration 2^CNT_W−1 cycles.
- `RINSE_W`, default 2: width of the rinse-count input.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a cycle; sampled only in IDLE.
- `pause` in 1: level; freezes the active stage while high.
- `abort` in 1: return to IDLE from any state; highest priority.
- `door_closed` in 1: door interlock, 1 = closed.
- `fill_time`, `wash_time`, `rinse_time`, `spin_time`, `drain_time` in CNT_W each: stage durations in cycles.
- `rinse_count` in RINSE_W: number of RINSE+DRAIN pairs.
- `stage` out 3: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DRAIN, 6 DONE, 7 ERROR.
- `busy` out 1: high in stages 1–5.
- `paused` out 1: high while busy and `pause` = 1.
- `done` out 1: high only in DONE, which is a single cycle.
- `error` out 1: high in ERROR.
- `remaining` out CNT_W: cycles left in the current stage after this one. Equals the stage timer; 0 outside busy stages.

## Operation
- **Reset:** all outputs are 0 (`stage` = IDLE); the timer, rinse counter and latched durations are cleared.
- **IDLE → FILL:** on `start` = 1 with `door_closed` = 1. The five durations and `rinse_count` are latched on the same edge. `start` with the door open is ignored. `start` outside IDLE is ignored.
- **Stage entry:** the timer is loaded with (latched duration − 1). A duration of 0 is treated as 1.
- **Timer:** each non-paused cycle, if the timer ≠ 0 it decrements; otherwise the stage exits.
- **Transitions:**
  - FILL → WASH → DRAIN.
  - DRAIN → RINSE if `rinse_left` ≠ 0; `rinse_left` decrements on RINSE entry.
  - DRAIN → SPIN if `rinse_left` = 0.
  - RINSE → DRAIN.
  - SPIN → DONE → IDLE (unconditional, after 1 cycle).
- **Pause:** while busy and `pause` = 1, the state, timer and `rinse_left` hold. `pause` has no effect in IDLE, DONE or ERROR.
- **Door interlock:**
  - `door_closed` = 0 while busy and `pause` = 0 → ERROR on the next edge.
  - The door may open while paused. Releasing `pause` with the door still open → ERROR.
- **ERROR:** held until `abort` or reset; `abort` → IDLE.
- **Abort:** `abort` = 1 in any non-IDLE state → IDLE next edge, with no DONE/`done` and counters cleared.
- **Priority:** `abort` > door fault > pause > timer expiry.
- **Width:** `remaining` and the timer are CNT_W unsigned and never underflow. `rinse_count` = 2^RINSE_W−1 is a legal value.

## Timing
- `start` sampled at edge k → `stage` = FILL from edge k, `busy` = 1 in the same cycle.
- A stage of duration T occupies exactly T unpaused cycles. Paused cycles add 1:1.
- **Total cycles from start to DONE:**
  - Cycles from the FILL-entry edge to the DONE-entry edge = F + W + D + R·(Ri + D) + S, where F, W, D, Ri, S are the fill, wash, drain, rinse and spin durations (0 read as 1) and R = `rinse_count`.
  - DONE lasts 1 cycle, then IDLE.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- A `start` in the DONE cycle is ignored. The next start is accepted in IDLE, 1 cycle later at the earliest.
- An asynchronous reset mid-stage forces IDLE immediately, with no DONE.

## Test plan
- **Nominal run:** all durations 2, `rinse_count` = 1, door closed, one `start` pulse.
  - Required stage sequence: 1,1,2,2,5,5,3,3,5,5,4,4,6, then 0.
  - `done` is high for exactly 1 cycle, 13 cycles after start.
- **Zero rinse / zero duration:** `rinse_count` = 0 and `wash_time` = 0.
  - Required sequence: FILL, WASH (1 cycle), DRAIN, SPIN, DONE; RINSE is never entered.
- **Pause in WASH:** assert `pause` for 5 cycles when `remaining` = 1.
  - `paused` = 1 and `stage` and `remaining` are frozen for 5 cycles.
  - The total run is 5 cycles longer than nominal.
- **Door fault:**
  - Case 1: drop `door_closed` mid-SPIN → `stage` = 7 and `error` = 1 next cycle, held until `abort`, then IDLE.
  - Case 2: open the door during pause, then release `pause` → ERROR.
- **Ignored start:** `start` with the door open → stays IDLE. `start` pulses during WASH → no restart and no change to the latched durations.
- **Abort/reset mid-run:** `abort` in RINSE → IDLE next cycle, `done` never asserts. An asynchronous reset in FILL → all outputs are 0 immediately.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine cycle sequencer: FILL, WASH, DRAIN, (RINSE, DRAIN) x N, SPIN, DONE.
// Supports pause, door-interlock fault and abort; all outputs come from registered state.
module wash_cycle_ctrl #(
  parameter int CNT_W   = 8,
  parameter int RINSE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic               door_closed,
  input  logic [CNT_W-1:0]   fill_time,
  input  logic [CNT_W-1:0]   wash_time,
  input  logic [CNT_W-1:0]   rinse_time,
  input  logic [CNT_W-1:0]   spin_time,
  input  logic [CNT_W-1:0]   drain_time,
  input  logic [RINSE_W-1:0] rinse_count,
  output logic [2:0]         stage,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic               error,
  output logic [CNT_W-1:0]   remaining
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } stage_e;

  stage_e             stage_q, stage_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RINSE_W-1:0] rinse_left_q, rinse_left_d;
  logic [CNT_W-1:0]   wash_q, wash_d;
  logic [CNT_W-1:0]   rinse_q, rinse_d;
  logic [CNT_W-1:0]   spin_q, spin_d;
  logic [CNT_W-1:0]   drain_q, drain_d;
  logic               paused_q, paused_d;
  logic               busy_w;

  // Zero-length stages still occupy one cycle.
  function automatic logic [CNT_W-1:0] load_val(
    input logic [CNT_W-1:0] dur
  );
    return (dur == '0) ? '0 : dur - CNT_W'(1);
  endfunction

  assign busy_w = (stage_q == S_FILL)  ||
                  (stage_q == S_WASH)  ||
                  (stage_q == S_RINSE) ||
                  (stage_q == S_SPIN)  ||
                  (stage_q == S_DRAIN);

  always_comb begin
    stage_d      = stage_q;
    timer_d      = timer_q;
    rinse_left_d = rinse_left_q;
    wash_d       = wash_q;
    rinse_d      = rinse_q;
    spin_d       = spin_q;
    drain_d      = drain_q;
    paused_d     = 1'b0;

    if (abort) begin
      stage_d      = S_IDLE;
      timer_d      = '0;
      rinse_left_d = '0;
    end else if (busy_w && !door_closed && !pause) begin
      stage_d      = S_ERROR;
      timer_d      = '0;
      rinse_left_d = '0;
    end else if (busy_w && pause) begin
      paused_d = 1'b1;
    end else if (busy_w && timer_q != '0) begin
      timer_d = timer_q - CNT_W'(1);
    end else begin
      unique case (stage_q)
        S_IDLE: begin
          if (start && door_closed) begin
            stage_d      = S_FILL;
            timer_d      = load_val(fill_time);
            rinse_left_d = rinse_count;
            wash_d       = wash_time;
            rinse_d      = rinse_time;
            spin_d       = spin_time;
            drain_d      = drain_time;
          end
        end
        S_FILL: begin
          stage_d = S_WASH;
          timer_d = load_val(wash_q);
        end
        S_WASH: begin
          stage_d = S_DRAIN;
          timer_d = load_val(drain_q);
        end
        S_DRAIN: begin
          if (rinse_left_q != '0) begin
            stage_d      = S_RINSE;
            timer_d      = load_val(rinse_q);
            rinse_left_d = rinse_left_q - RINSE_W'(1);
          end else begin
            stage_d = S_SPIN;
            timer_d = load_val(spin_q);
          end
        end
        S_RINSE: begin
          stage_d = S_DRAIN;
          timer_d = load_val(drain_q);
        end
        S_SPIN: begin
          stage_d = S_DONE;
          timer_d = '0;
        end
        S_DONE: begin
          stage_d = S_IDLE;
        end
        S_ERROR: begin
          stage_d = S_ERROR;
        end
        default: begin
          stage_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q      <= S_IDLE;
      timer_q      <= '0;
      rinse_left_q <= '0;
      wash_q       <= '0;
      rinse_q      <= '0;
      spin_q       <= '0;
      drain_q      <= '0;
      paused_q     <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      timer_q      <= timer_d;
      rinse_left_q <= rinse_left_d;
      wash_q       <= wash_d;
      rinse_q      <= rinse_d;
      spin_q       <= spin_d;
      drain_q      <= drain_d;
      paused_q     <= paused_d;
    end
  end

  assign stage     = stage_q;
  assign busy      = busy_w;
  assign paused    = paused_q;
  assign done      = (stage_q == S_DONE);
  assign error     = (stage_q == S_ERROR);
  assign remaining = busy_w ? timer_q : '0;

endmodule
